// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and default parameters for the serializer
package piso_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_DATA_W    = 8;
  localparam bit DEF_MSB_FIRST = 1'b1;
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: loadable down-counter with zero flag
module piso_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (load) count <= load_val;
    else if (dec) count <= count - W'(1);
  assign zero = count == '0;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with gapless back-to-back words
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              serial_o,
  output logic              frame_o,
  output logic              done_o
);
  localparam int CW = $clog2(DATA_W) + 1;
  state_t state, state_nx;
  logic [DATA_W-1:0] sr;
  logic [CW-1:0] count;
  logic zero, last, accept, dec;
  assign last    = state == SHIFT && zero;
  assign done_o  = last;
  assign ready_o = !reset && (state == IDLE || last);
  assign accept  = valid_i && ready_o;
  assign dec     = state == SHIFT && !zero;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = accept ? SHIFT : last ? IDLE : state;
  piso_bit_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (CW'(DATA_W - 1)),
    .dec      (dec),
    .count    (count),
    .zero     (zero)
  );
  // sr holds only the bits not yet emitted; the first bit goes straight to serial_o
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sr       <= '0;
      serial_o <= 1'b0;
      frame_o  <= 1'b0;
    end else if (accept) begin
      serial_o <= MSB_FIRST ? data_i[DATA_W-1] : data_i[0];
      sr       <= MSB_FIRST ? data_i << 1 : data_i >> 1;
      frame_o  <= 1'b1;
    end else if (dec) begin
      serial_o <= MSB_FIRST ? sr[DATA_W-1] : sr[0];
      sr       <= MSB_FIRST ? sr << 1 : sr >> 1;
    end else if (last) begin
      serial_o <= 1'b0;
      frame_o  <= 1'b0;
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of MSB/LSB-first, streaming, busy-ignore, reset abort, width 1
module tb_piso_serializer;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] d_m = '0, d_l = '0;
  logic d_w = 1'b0;
  logic v_m = 1'b0, v_l = 1'b0, v_w = 1'b0;
  logic s_m, f_m, dn_m, r_m, s_l, f_l, dn_l, r_l, s_w, f_w, dn_w, r_w;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  piso_serializer #(.DATA_W(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .data_i(d_m), .valid_i(v_m),
    .ready_o(r_m), .serial_o(s_m), .frame_o(f_m), .done_o(dn_m));
  piso_serializer #(.DATA_W(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .data_i(d_l), .valid_i(v_l),
    .ready_o(r_l), .serial_o(s_l), .frame_o(f_l), .done_o(dn_l));
  piso_serializer #(.DATA_W(1), .MSB_FIRST(1)) u_w1 (
    .clk(clk), .reset(reset), .data_i(d_w), .valid_i(v_w),
    .ready_o(r_w), .serial_o(s_w), .frame_o(f_w), .done_o(dn_w));

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({s_m, f_m, dn_m, r_m, s_l, f_l, dn_l, r_l, s_w, f_w, dn_w, r_w} !== 12'b0) begin
      failures++;
      $display("FAIL reset_held: got %b expected %b",
               {s_m, f_m, dn_m, r_m, s_l, f_l, dn_l, r_l, s_w, f_w, dn_w, r_w}, 12'b0);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({r_m, r_l, r_w, f_m, f_l, f_w} !== 6'b111000) begin
      failures++;
      $display("FAIL reset_release: got %b expected %b", {r_m, r_l, r_w, f_m, f_l, f_w}, 6'b111000);
    end
  endtask

  task automatic test_msb_first;
    logic [7:0] seq = 8'b0001_0010;
    logic [3:0] e;
    @(negedge clk);
    checks++;
    if (r_m !== 1'b1) begin failures++; $display("FAIL msb_ready0: got %b expected 1", r_m); end
    v_m = 1'b1; d_m = 8'h12;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin v_m = 1'b0; d_m = 8'hFF; end
      e = {seq[8-i], 1'b1, i == 8, i == 8};
      checks++;
      if ({s_m, f_m, dn_m, r_m} !== e) begin
        failures++;
        $display("FAIL msb_first cycle %0d: got %b expected %b", i, {s_m, f_m, dn_m, r_m}, e);
      end
    end
    @(negedge clk);
    checks++;
    if ({s_m, f_m, dn_m, r_m} !== 4'b0001) begin
      failures++;
      $display("FAIL msb_idle: got %b expected %b", {s_m, f_m, dn_m, r_m}, 4'b0001);
    end
  endtask

  task automatic test_lsb_first;
    logic [7:0] seq = 8'b0100_1000;
    logic [3:0] e;
    @(negedge clk);
    v_l = 1'b1; d_l = 8'h12;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) v_l = 1'b0;
      e = {seq[8-i], 1'b1, i == 8, i == 8};
      checks++;
      if ({s_l, f_l, dn_l, r_l} !== e) begin
        failures++;
        $display("FAIL lsb_first cycle %0d: got %b expected %b", i, {s_l, f_l, dn_l, r_l}, e);
      end
    end
    @(negedge clk);
    checks++;
    if ({s_l, f_l, dn_l, r_l} !== 4'b0001) begin
      failures++;
      $display("FAIL lsb_idle: got %b expected %b", {s_l, f_l, dn_l, r_l}, 4'b0001);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] e;
    @(negedge clk);
    v_m = 1'b1; d_m = 8'hFF;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) d_m = 8'h00;
      if (i == 9) v_m = 1'b0;
      e = {i <= 8, 1'b1, i == 8 || i == 16, i == 8 || i == 16};
      checks++;
      if ({s_m, f_m, dn_m, r_m} !== e) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", i, {s_m, f_m, dn_m, r_m}, e);
      end
    end
    @(negedge clk);
    checks++;
    if ({s_m, f_m, dn_m, r_m} !== 4'b0001) begin
      failures++;
      $display("FAIL b2b_idle: got %b expected %b", {s_m, f_m, dn_m, r_m}, 4'b0001);
    end
  endtask

  task automatic test_ignore_busy;
    logic [15:0] seq = 16'hF055;
    logic [3:0] e;
    @(negedge clk);
    v_m = 1'b1; d_m = 8'hF0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1 || i == 6 || i == 9) v_m = 1'b0;
      if (i == 2 || i == 8) begin v_m = 1'b1; d_m = 8'h55; end
      e = {seq[16-i], 1'b1, i == 8 || i == 16, i == 8 || i == 16};
      checks++;
      if ({s_m, f_m, dn_m, r_m} !== e) begin
        failures++;
        $display("FAIL ignore_busy cycle %0d: got %b expected %b", i, {s_m, f_m, dn_m, r_m}, e);
      end
    end
    @(negedge clk);
    checks++;
    if ({s_m, f_m, dn_m, r_m} !== 4'b0001) begin
      failures++;
      $display("FAIL ignore_idle: got %b expected %b", {s_m, f_m, dn_m, r_m}, 4'b0001);
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] a5 = 4'b1010;
    logic [7:0] seq = 8'b0011_1100;
    logic [3:0] e;
    @(negedge clk);
    v_m = 1'b1; d_m = 8'hA5;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) v_m = 1'b0;
      e = {a5[4-i], 1'b1, 1'b0, 1'b0};
      checks++;
      if ({s_m, f_m, dn_m, r_m} !== e) begin
        failures++;
        $display("FAIL abort_pre cycle %0d: got %b expected %b", i, {s_m, f_m, dn_m, r_m}, e);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({s_m, f_m, dn_m, r_m} !== 4'b0000) begin
      failures++;
      $display("FAIL abort_async: got %b expected %b", {s_m, f_m, dn_m, r_m}, 4'b0000);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({s_m, f_m, dn_m, r_m} !== 4'b0001) begin
      failures++;
      $display("FAIL abort_release: got %b expected %b", {s_m, f_m, dn_m, r_m}, 4'b0001);
    end
    @(negedge clk);
    checks++;
    if ({s_m, f_m, dn_m, r_m} !== 4'b0001) begin
      failures++;
      $display("FAIL abort_no_tail: got %b expected %b", {s_m, f_m, dn_m, r_m}, 4'b0001);
    end
    v_m = 1'b1; d_m = 8'h3C;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) v_m = 1'b0;
      e = {seq[8-i], 1'b1, i == 8, i == 8};
      checks++;
      if ({s_m, f_m, dn_m, r_m} !== e) begin
        failures++;
        $display("FAIL after_reset cycle %0d: got %b expected %b", i, {s_m, f_m, dn_m, r_m}, e);
      end
    end
  endtask

  task automatic test_width1;
    logic [3:0] seq = 4'b1011;
    logic [3:0] e;
    @(negedge clk);
    checks++;
    if (r_w !== 1'b1) begin failures++; $display("FAIL w1_ready0: got %b expected 1", r_w); end
    v_w = 1'b1; d_w = seq[3];
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      e = {seq[4-i], 3'b111};
      checks++;
      if ({s_w, f_w, dn_w, r_w} !== e) begin
        failures++;
        $display("FAIL width1 cycle %0d: got %b expected %b", i, {s_w, f_w, dn_w, r_w}, e);
      end
      if (i < 4) d_w = seq[3-i];
      else v_w = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({s_w, f_w, dn_w, r_w} !== 4'b0001) begin
      failures++;
      $display("FAIL w1_idle: got %b expected %b", {s_w, f_w, dn_w, r_w}, 4'b0001);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
